// File: rtl/mtr_pkg.sv
// Shared types and constants for the motor duty ramp block.
package mtr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam logic [10:0]        MID_DUTY = 11'h400;
  localparam logic signed [11:0] SPD_MAX  = 12'sd1023;

  // Clamp a raw 12-bit speed to the symmetric range the PWM can express.
  function automatic logic signed [11:0] sat_spd(input logic signed [11:0] spd);
    if (spd > SPD_MAX) begin
      return SPD_MAX;
    end else if (spd < -SPD_MAX) begin
      return -SPD_MAX;
    end else begin
      return spd;
    end
  endfunction

  // Offset-binary duty word; the 11-bit wrap maps -1023 onto 0x001.
  function automatic logic [10:0] to_duty(input logic signed [11:0] app);
    return MID_DUTY + app[10:0];
  endfunction

endpackage

// File: rtl/mtr_duty_ramp_slew_lim.sv
// One side of the ramp: saturate the target, slew the applied speed toward it.
module slew_lim
  import mtr_pkg::*;
#(
  parameter int RAMP_STEP = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               zero_i,
  input  logic signed [11:0] tgt_i,
  output logic signed [11:0] app_d_o,
  output logic               at_tgt_o
);

  localparam logic signed [12:0] STEP = 13'(RAMP_STEP);

  logic signed [11:0] app_q;
  logic signed [11:0] app_d;
  logic signed [11:0] tgt_eff;
  logic signed [12:0] diff;
  logic signed [12:0] sum;

  // Next applied speed, computed in 13 bits so target minus applied never overflows.
  always_comb begin
    tgt_eff = zero_i ? 12'sd0 : sat_spd(tgt_i);
    diff    = {tgt_eff[11], tgt_eff} - {app_q[11], app_q};
    sum     = {app_q[11], app_q};
    if (diff > STEP) begin
      sum = {app_q[11], app_q} + STEP;
    end else if (diff < -STEP) begin
      sum = {app_q[11], app_q} - STEP;
    end else begin
      sum = {tgt_eff[11], tgt_eff};
    end
    app_d = sum[11:0];
  end

  assign app_d_o  = app_d;
  assign at_tgt_o = (app_d == tgt_eff);

  // Applied speed only moves on the frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      app_q <= 12'sd0;
    end else if (tick_i) begin
      app_q <= app_d;
    end
  end

endmodule

// File: rtl/mtr_duty_ramp.sv
// Frame-synchronous duty ramp for a two-motor PWM stage.
module mtr_duty_ramp
  import mtr_pkg::*;
#(
  parameter int RAMP_STEP = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  output logic [10:0] lft_duty,
  output logic [10:0] rght_duty,
  output logic        duty_upd,
  output logic        settled
);

  logic [10:0]        frame_q;
  logic               tick;
  logic               zero_tgt;
  state_e             state_q, state_d;
  logic signed [11:0] lft_app_d, rght_app_d;
  logic               lft_at, rght_at;
  logic               settled_d;
  logic [10:0]        lft_duty_q, rght_duty_q;
  logic               duty_upd_q, settled_q;

  assign tick     = (frame_q == 11'h7FF);
  assign zero_tgt = ~en;

  slew_lim #(.RAMP_STEP(RAMP_STEP)) u_lft (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick),
    .zero_i   (zero_tgt),
    .tgt_i    ($signed(lft_spd)),
    .app_d_o  (lft_app_d),
    .at_tgt_o (lft_at)
  );

  slew_lim #(.RAMP_STEP(RAMP_STEP)) u_rght (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick),
    .zero_i   (zero_tgt),
    .tgt_i    ($signed(rght_spd)),
    .app_d_o  (rght_app_d),
    .at_tgt_o (rght_at)
  );

  // Free-running frame counter, aligned with the downstream PWM counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= 11'h000;
    end else begin
      frame_q <= frame_q + 11'h001;
    end
  end

  // Next state and settled flag; both sides share one enable so en alone picks the slew target.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = en ? RUN : IDLE;
      RUN:     state_d = en ? RUN : STOP;
      STOP: begin
        if (en) begin
          state_d = RUN;
        end else if ((lft_app_d == 12'sd0) && (rght_app_d == 12'sd0)) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase

    settled_d = 1'b0;
    case (state_d)
      IDLE:    settled_d = 1'b1;
      RUN:     settled_d = lft_at & rght_at;
      default: settled_d = 1'b0;
    endcase
  end

  // State and registered outputs update on the tick so the PWM sees new words at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lft_duty_q  <= MID_DUTY;
      rght_duty_q <= MID_DUTY;
      settled_q   <= 1'b1;
      duty_upd_q  <= 1'b0;
    end else begin
      duty_upd_q <= tick;
      if (tick) begin
        state_q     <= state_d;
        lft_duty_q  <= to_duty(lft_app_d);
        rght_duty_q <= to_duty(rght_app_d);
        settled_q   <= settled_d;
      end
    end
  end

  assign lft_duty  = lft_duty_q;
  assign rght_duty = rght_duty_q;
  assign duty_upd  = duty_upd_q;
  assign settled   = settled_q;

endmodule

// File: tb/tb_mtr_duty_ramp.sv
// Directed bench for mtr_duty_ramp; RAMP_STEP=100 keeps ramps to a few frames.
module tb_mtr_duty_ramp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] lft_spd = 12'h000;
  logic [11:0] rght_spd = 12'h000;
  logic [10:0] lft_duty, rght_duty;
  logic        duty_upd, settled;

  int total = 0;
  int bad = 0;
  int n;

  always #5 clk = ~clk;

  mtr_duty_ramp #(.RAMP_STEP(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .lft_duty  (lft_duty),
    .rght_duty (rght_duty),
    .duty_upd  (duty_upd),
    .settled   (settled)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next duty_upd pulse, sampled on negedges.
  task automatic wait_upd(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!duty_upd && cnt < 2100);
    chk("upd_seen", {31'b0, duty_upd}, 32'd1);
  endtask

  task automatic tick_chk(input string tag, input int el, input int er, input bit es);
    int c;
    wait_upd(c);
    chk({tag, "_lft"}, {21'b0, lft_duty}, el);
    chk({tag, "_rght"}, {21'b0, rght_duty}, er);
    chk({tag, "_settled"}, {31'b0, settled}, {31'b0, es});
  endtask

  initial begin
    // Reset state
    lft_spd  = 12'h100;
    rght_spd = 12'h100;
    repeat (3) @(negedge clk);
    chk("rst_lft", {21'b0, lft_duty}, 32'h400);
    chk("rst_rght", {21'b0, rght_duty}, 32'h400);
    chk("rst_upd", {31'b0, duty_upd}, 32'd0);
    chk("rst_settled", {31'b0, settled}, 32'd1);
    rst_n = 1'b1;

    // Disabled: duties hold mid, pulse every 2048 clocks
    wait_upd(n);
    chk("idle_first_gap", n, 2048);
    chk("idle_lft", {21'b0, lft_duty}, 32'h400);
    chk("idle_rght", {21'b0, rght_duty}, 32'h400);
    chk("idle_settled", {31'b0, settled}, 32'd1);
    @(negedge clk);
    chk("upd_one_cycle", {31'b0, duty_upd}, 32'd0);
    wait_upd(n);
    chk("idle_gap", n, 2047);

    // Ramp +256 / -256, with targets toggled between ticks before tick 2
    en       = 1'b1;
    lft_spd  = 12'h100;
    rght_spd = 12'hF00;
    tick_chk("ramp1", 'h464, 'h39C, 1'b0);
    repeat (500) @(negedge clk);
    lft_spd  = 12'h000;
    rght_spd = 12'h7FF;
    repeat (500) @(negedge clk);
    lft_spd  = 12'h100;
    rght_spd = 12'hF00;
    tick_chk("ramp2", 'h4C8, 'h338, 1'b0);
    tick_chk("ramp3", 'h500, 'h300, 1'b1);

    // Drop enable: STOP ramps to zero, then IDLE
    en = 1'b0;
    tick_chk("stop1", 'h49C, 'h364, 1'b0);
    tick_chk("stop2", 'h438, 'h3C8, 1'b0);
    tick_chk("stop3", 'h400, 'h400, 1'b1);
    tick_chk("stop_idle", 'h400, 'h400, 1'b1);

    // Full-scale targets saturate to +/-1023, last step is partial
    en       = 1'b1;
    lft_spd  = 12'h800;
    rght_spd = 12'h7FF;
    for (int k = 1; k <= 11; k++) begin
      tick_chk($sformatf("sat%0d", k),
               (k < 11) ? ('h400 - 100 * k) : 'h001,
               (k < 11) ? ('h400 + 100 * k) : 'h7FF,
               k == 11);
    end

    // Reset mid-ramp, mid-frame
    lft_spd  = 12'h100;
    rght_spd = 12'hF00;
    tick_chk("pre_rst", 'h065, 'h79B, 1'b0);
    repeat (700) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_lft", {21'b0, lft_duty}, 32'h400);
    chk("mid_rst_rght", {21'b0, rght_duty}, 32'h400);
    chk("mid_rst_upd", {31'b0, duty_upd}, 32'd0);
    chk("mid_rst_settled", {31'b0, settled}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_upd(n);
    chk("post_rst_gap", n, 2048);
    chk("post_rst_lft", {21'b0, lft_duty}, 32'h464);
    chk("post_rst_rght", {21'b0, rght_duty}, 32'h39C);
    tick_chk("post_rst2", 'h4C8, 'h338, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
